// File: rtl/write_trace_checker_if.sv
// write_trace_checker_if: bundles the checker's load port, run control,
// observed CPU write ports and result outputs.
//   master : harness/CPU side (drives load, control and observed writes)
//   slave  : checker side (samples them, drives status and results)
interface write_trace_checker_if #(
  parameter int LOGWIDTH = 5,
  parameter int CHANNELS = 2,
  parameter int DEPTHLOG = 10
);
  localparam int W  = 2 ** LOGWIDTH;
  localparam int VW = 1 + CHANNELS * (2 * W + 1);

  logic                     ciLoad;
  logic [DEPTHLOG-1:0]      diLoadAddr;
  logic [VW-1:0]            diLoadData;
  logic                     ciStart;
  logic                     ciStop;
  logic [CHANNELS*W-1:0]    diWD;
  logic [CHANNELS*W-1:0]    diADR;
  logic [CHANNELS-1:0]      ciWE;
  logic                     coBusy;
  logic                     coDone;
  logic                     coPass;
  logic [31:0]              doErrors;
  logic [DEPTHLOG:0]        doVecNum;
  logic [DEPTHLOG-1:0]      doFirstIdx;
  logic [7:0]               doFirstCh;
  logic                     coFirstValid;

  modport master (
    output ciLoad, diLoadAddr, diLoadData, ciStart, ciStop, diWD, diADR, ciWE,
    input  coBusy, coDone, coPass, doErrors, doVecNum, doFirstIdx, doFirstCh, coFirstValid
  );

  modport slave (
    input  ciLoad, diLoadAddr, diLoadData, ciStart, ciStop, diWD, diADR, ciWE,
    output coBusy, coDone, coPass, doErrors, doVecNum, doFirstIdx, doFirstCh, coFirstValid
  );
endinterface

// File: rtl/write_trace_checker.sv
// write_trace_checker: replays an expected-vector RAM against the CPU write
// ports, one entry per clock, counting mismatches and capturing the first one.
// Ports:
//   clk      : clock, all state on the rising edge
//   ci_rst_n : asynchronous active-low reset (RAM contents survive it)
//   bus      : slave side of write_trace_checker_if (load port, start/stop,
//              observed WD/ADR/WE per channel, busy/done/pass, error count,
//              compared-entry count, first-mismatch index/channel/valid)
// Vector word: MSB = end marker, channel c at [c*(2W+1) +: 2W+1] = {WD, ADR, WE}.
module write_trace_checker #(
  parameter int LOGWIDTH = 5,
  parameter int CHANNELS = 2,
  parameter int DEPTHLOG = 10,
  parameter int MASKED   = 0
) (
  input  logic                  clk,
  input  logic                  ci_rst_n,
  write_trace_checker_if.slave  bus
);
  localparam int W  = 2 ** LOGWIDTH;
  localparam int CW = 2 * W + 1;
  localparam int VW = 1 + CHANNELS * CW;
  localparam int D  = 2 ** DEPTHLOG;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [31:0] f_popcount(input logic [CHANNELS-1:0] v);
    logic [31:0] n;
    n = 32'd0;
    for (int i = 0; i < CHANNELS; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

  function automatic logic [7:0] f_lowest(input logic [CHANNELS-1:0] v);
    logic [7:0] idx;
    idx = 8'd0;
    // Scan downwards so the lowest set index is the one left standing.
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 8'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_t              r_state;
  logic [VW-1:0]       r_mem [D];
  logic [VW-1:0]       r_rdata;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic [31:0]         r_errors;
  logic [DEPTHLOG:0]   r_vecnum;
  logic [DEPTHLOG-1:0] r_first_idx;
  logic [7:0]          r_first_ch;
  logic                r_first_valid;

  logic                w_load_en;
  logic [DEPTHLOG-1:0] w_rd_addr;
  logic [CHANNELS-1:0] w_mism;
  logic [32:0]         w_err_sum;
  logic [31:0]         w_err_next;
  logic                w_marker;
  logic                w_last;

  // The RAM may only be rewritten while no run is in flight.
  assign w_load_en = bus.ciLoad && ((r_state == S_IDLE) || (r_state == S_DONE));
  // In RUN, entry k is being compared, so entry k+1 is fetched; otherwise entry 0.
  assign w_rd_addr = (r_state == S_RUN) ? (r_vecnum[DEPTHLOG-1:0] + DEPTHLOG'(1))
                                        : {DEPTHLOG{1'b0}};
  assign w_marker  = r_rdata[VW-1];
  assign w_last    = (r_vecnum == (DEPTHLOG + 1)'(D - 1));
  assign w_err_sum = {1'b0, r_errors} + {1'b0, f_popcount(w_mism)};
  assign w_err_next = w_err_sum[32] ? 32'hFFFF_FFFF : w_err_sum[31:0];

  // Vector RAM, write-first so a same-edge load/read returns the new word.
  always_ff @(posedge clk) begin
    if (w_load_en) begin
      r_mem[bus.diLoadAddr] <= bus.diLoadData;
    end
    if (w_load_en && (bus.diLoadAddr == w_rd_addr)) begin
      r_rdata <= bus.diLoadData;
    end else begin
      r_rdata <= r_mem[w_rd_addr];
    end
  end

  // Per-channel compare of the registered entry against the live write ports.
  always_comb begin
    w_mism = {CHANNELS{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      if ((MASKED != 0) && !r_rdata[c*CW]) begin
        // Expected no write: only a spurious write counts.
        w_mism[c] = bus.ciWE[c];
      end else begin
        w_mism[c] = (bus.ciWE[c] != r_rdata[c*CW])
                 || (bus.diADR[c*W +: W] != r_rdata[c*CW+1 +: W])
                 || (bus.diWD[c*W +: W]  != r_rdata[c*CW+1+W +: W]);
      end
    end
  end

  // Run-control FSM with registered status and result outputs.
  always_ff @(posedge clk or negedge ci_rst_n) begin
    if (!ci_rst_n) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_errors      <= 32'd0;
      r_vecnum      <= {(DEPTHLOG + 1){1'b0}};
      r_first_idx   <= {DEPTHLOG{1'b0}};
      r_first_ch    <= 8'd0;
      r_first_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // Start takes priority over a concurrent stop.
          if (bus.ciStart) begin
            r_state       <= S_PRIME;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_errors      <= 32'd0;
            r_vecnum      <= {(DEPTHLOG + 1){1'b0}};
            r_first_valid <= 1'b0;
          end else begin
            r_state <= r_state;
          end
        end
        S_PRIME: begin
          if (bus.ciStop) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_errors == 32'd0);
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.ciStop || w_marker) begin
            // Neither an aborted cycle nor a marker entry is compared.
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_errors == 32'd0);
          end else begin
            r_errors <= w_err_next;
            r_vecnum <= r_vecnum + (DEPTHLOG + 1)'(1);
            if (!r_first_valid && (|w_mism)) begin
              r_first_valid <= 1'b1;
              r_first_idx   <= r_vecnum[DEPTHLOG-1:0];
              r_first_ch    <= f_lowest(w_mism);
            end else begin
              r_first_valid <= r_first_valid;
            end
            // The pointer stops at the final entry instead of wrapping.
            if (w_last) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == 32'd0);
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.coBusy       = r_busy;
  assign bus.coDone       = r_done;
  assign bus.coPass       = r_pass;
  assign bus.doErrors     = r_errors;
  assign bus.doVecNum     = r_vecnum;
  assign bus.doFirstIdx   = r_first_idx;
  assign bus.doFirstCh    = r_first_ch;
  assign bus.coFirstValid = r_first_valid;
endmodule

// File: tb/tb_write_trace_checker.sv
// Table-driven bench: u0 is strict (MASKED=0, DEPTHLOG=10), u1 is masked with
// a 4-entry RAM (MASKED=1, DEPTHLOG=2). Both share all inputs.
module tb_write_trace_checker;
  localparam int W  = 32;
  localparam int CW = 2 * W + 1;
  localparam int VW = 1 + 2 * CW;
  localparam logic [VW-1:0] MARK = {1'b1, {(VW-1){1'b0}}};

  typedef struct {
    int err0; int vn0; int fv0; int fidx0; int fch0; int pass0; int cyc0;
    int err1; int vn1; int pass1; int cyc1;
  } exp_t;

  typedef struct {
    logic [4:0][VW-1:0] ent;
    logic [4:0][63:0]   wd;
    logic [4:0][63:0]   adr;
    logic [4:0][1:0]    we;
    exp_t               ex;
  } scn_t;

  logic clk;
  logic rst_n;
  logic          t_load;
  logic [9:0]    t_addr;
  logic [VW-1:0] t_data;
  logic          t_start;
  logic          t_stop;
  logic [63:0]   t_wd;
  logic [63:0]   t_adr;
  logic [1:0]    t_we;

  int   n_checks;
  int   n_errors;
  scn_t tbl [7];
  scn_t base;

  write_trace_checker_if #(.LOGWIDTH(5), .CHANNELS(2), .DEPTHLOG(10)) b0 ();
  write_trace_checker_if #(.LOGWIDTH(5), .CHANNELS(2), .DEPTHLOG(2))  b1 ();

  write_trace_checker #(.LOGWIDTH(5), .CHANNELS(2), .DEPTHLOG(10), .MASKED(0)) u0 (
    .clk(clk), .ci_rst_n(rst_n), .bus(b0.slave));
  write_trace_checker #(.LOGWIDTH(5), .CHANNELS(2), .DEPTHLOG(2), .MASKED(1)) u1 (
    .clk(clk), .ci_rst_n(rst_n), .bus(b1.slave));

  assign b0.ciLoad = t_load;   assign b1.ciLoad = t_load;
  assign b0.diLoadAddr = t_addr; assign b1.diLoadAddr = t_addr[1:0];
  assign b0.diLoadData = t_data; assign b1.diLoadData = t_data;
  assign b0.ciStart = t_start; assign b1.ciStart = t_start;
  assign b0.ciStop = t_stop;   assign b1.ciStop = t_stop;
  assign b0.diWD = t_wd;       assign b1.diWD = t_wd;
  assign b0.diADR = t_adr;     assign b1.diADR = t_adr;
  assign b0.ciWE = t_we;       assign b1.ciWE = t_we;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CW-1:0] chw(input logic [31:0] wd, input logic [31:0] adr,
                                        input logic we);
    return {wd, adr, we};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic load_entry(input int a, input logic [VW-1:0] d);
    @(negedge clk);
    t_load = 1'b1; t_addr = 10'(a); t_data = d;
    @(posedge clk);
    @(negedge clk);
    t_load = 1'b0;
  endtask

  task automatic load_scn(input int i);
    // Entry 4 first: on u1 it aliases address 0, which is then overwritten.
    load_entry(4, tbl[i].ent[4]);
    for (int a = 0; a < 4; a++) load_entry(a, tbl[i].ent[a]);
  endtask

  task automatic drive(input int i, input int t);
    if (t < 5) begin
      t_wd = tbl[i].wd[t]; t_adr = tbl[i].adr[t]; t_we = tbl[i].we[t];
    end else begin
      t_wd = 64'd0; t_adr = 64'd0; t_we = 2'b00;
    end
  endtask

  task automatic start_run();
    @(negedge clk); t_start = 1'b1;
    @(posedge clk);
    @(negedge clk); t_start = 1'b0;
    @(posedge clk);
  endtask

  task automatic run_scn(input int i, input bit do_load);
    int c0;
    int c1;
    if (do_load) load_scn(i);
    start_run();
    c0 = 0; c1 = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk); drive(i, t);
      @(posedge clk); #1;
      if (b0.coDone && c0 == 0) c0 = t + 2;
      if (b1.coDone && c1 == 0) c1 = t + 2;
      if (c0 != 0 && c1 != 0) break;
    end
    chk($sformatf("s%0d_cyc0", i), 64'(c0), 64'(tbl[i].ex.cyc0));
    chk($sformatf("s%0d_err0", i), 64'(b0.doErrors), 64'(tbl[i].ex.err0));
    chk($sformatf("s%0d_vn0", i), 64'(b0.doVecNum), 64'(tbl[i].ex.vn0));
    chk($sformatf("s%0d_fv0", i), 64'(b0.coFirstValid), 64'(tbl[i].ex.fv0));
    chk($sformatf("s%0d_pass0", i), 64'(b0.coPass), 64'(tbl[i].ex.pass0));
    chk($sformatf("s%0d_busy0", i), 64'(b0.coBusy), 64'd0);
    if (tbl[i].ex.fv0 != 0) begin
      chk($sformatf("s%0d_fidx0", i), 64'(b0.doFirstIdx), 64'(tbl[i].ex.fidx0));
      chk($sformatf("s%0d_fch0", i), 64'(b0.doFirstCh), 64'(tbl[i].ex.fch0));
    end
    chk($sformatf("s%0d_cyc1", i), 64'(c1), 64'(tbl[i].ex.cyc1));
    chk($sformatf("s%0d_err1", i), 64'(b1.doErrors), 64'(tbl[i].ex.err1));
    chk($sformatf("s%0d_vn1", i), 64'(b1.doVecNum), 64'(tbl[i].ex.vn1));
    chk($sformatf("s%0d_pass1", i), 64'(b1.coPass), 64'(tbl[i].ex.pass1));
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; t_load = 1'b0; t_addr = 10'd0; t_data = '0;
    t_start = 1'b0; t_stop = 1'b0; t_wd = 64'd0; t_adr = 64'd0; t_we = 2'b00;

    // Base trace: ch0 = data memory, ch1 = register file; entry 4 is a marker.
    for (int k = 0; k < 5; k++) begin
      logic [31:0] w0, a0, w1, a1;
      w0 = 32'h100 + 32'(k); a0 = 32'h40 + 32'(4 * k);
      w1 = 32'h6 + 32'(k);   a1 = 32'h1 + 32'(k);
      base.ent[k] = {1'b0, chw(w1, a1, 1'b1), chw(w0, a0, 1'b1)};
      base.wd[k] = {w1, w0}; base.adr[k] = {a1, a0}; base.we[k] = 2'b11;
    end
    base.ent[4] = MARK;
    for (int i = 0; i < 7; i++) tbl[i] = base;
    // 0: three matching entries then marker
    tbl[0].ent[3] = MARK;
    tbl[0].ex = '{0, 3, 0, 0, 0, 1, 5, 0, 3, 1, 5};
    // 1: entry 1 ch1 expects WD=7, CPU writes 8
    tbl[1].ent[3] = MARK; tbl[1].wd[1][63:32] = 32'h8;
    tbl[1].ex = '{1, 3, 1, 1, 1, 0, 5, 1, 3, 0, 5};
    // 2: entry 2 mismatches on both channels
    tbl[2].ent[3] = MARK; tbl[2].wd[2] = tbl[2].wd[2] ^ 64'h0000_0001_0000_0001;
    tbl[2].ex = '{2, 3, 1, 2, 0, 0, 5, 2, 3, 0, 5};
    // 3: both of the above; first capture stays at entry 1
    tbl[3].ent[3] = MARK; tbl[3].wd[1][63:32] = 32'h8;
    tbl[3].wd[2] = tbl[3].wd[2] ^ 64'h0000_0001_0000_0001;
    tbl[3].ex = '{3, 3, 1, 1, 1, 0, 5, 3, 3, 0, 5};
    // 4: expected ch0 WE=0 ADR=0x10, CPU ADR=0x44 WE=0 -> strict only flags it
    tbl[4].ent[0] = {tbl[4].ent[0][VW-1:CW], chw(32'h0, 32'h10, 1'b0)};
    tbl[4].ent[1] = MARK; tbl[4].adr[0][31:0] = 32'h44; tbl[4].we[0] = 2'b10;
    tbl[4].ex = '{1, 1, 1, 0, 0, 0, 3, 0, 1, 1, 3};
    // 5: expected ch0 WE=0 but CPU writes -> both modes flag it
    tbl[5].ent[0] = {tbl[5].ent[0][VW-1:CW], chw(32'h0, 32'h10, 1'b0)};
    tbl[5].ent[1] = MARK; tbl[5].adr[0][31:0] = 32'h44; tbl[5].we[0] = 2'b11;
    tbl[5].ex = '{1, 1, 1, 0, 0, 0, 3, 1, 1, 0, 3};
    // 6: no marker in 0..3; u1 stops at its last entry, u0 at the marker at 4
    tbl[6].ex = '{0, 4, 0, 0, 0, 1, 6, 0, 4, 1, 5};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out0", {b0.coBusy, b0.coDone, b0.coPass, b0.coFirstValid, b0.doErrors,
                     21'(b0.doVecNum), 8'(b0.doFirstCh)}, 64'd0);
    chk("rst_out1", {b1.coBusy, b1.coDone, b1.coPass, b1.coFirstValid, b1.doErrors,
                     8'(b1.doVecNum), 8'(b1.doFirstCh)}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_scn(i, 1'b1);

    // Load concurrent with start: marker written to entry 0 on the start edge.
    @(negedge clk); t_load = 1'b1; t_addr = 10'd0; t_data = MARK; t_start = 1'b1;
    @(posedge clk);
    @(negedge clk); t_load = 1'b0; t_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ldstart_done", 64'(b0.coDone), 64'd1);
    chk("ldstart_vn", 64'(b0.doVecNum), 64'd0);

    // Stop in RUN after one compare; the aborted cycle carries bad data.
    load_scn(0);
    start_run();
    @(negedge clk); drive(0, 0);
    @(posedge clk);
    @(negedge clk); t_stop = 1'b1; t_wd = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #1;
    chk("stop_done", 64'({b0.coDone, b0.coBusy}), 64'b10);
    chk("stop_vn", 64'(b0.doVecNum), 64'd1);
    chk("stop_err", 64'(b0.doErrors), 64'd0);
    chk("stop_pass", 64'(b0.coPass), 64'd1);
    // Start and stop together in DONE: start wins.
    @(negedge clk); t_start = 1'b1;
    @(posedge clk); #1;
    chk("startstop_busy", 64'({b0.coBusy, b0.coDone}), 64'b10);
    // Stop during PRIME goes straight to DONE.
    @(negedge clk); t_start = 1'b0;
    @(posedge clk); #1;
    chk("prime_stop", 64'({b0.coBusy, b0.coDone}), 64'b01);
    chk("prime_stop_vn", 64'(b0.doVecNum), 64'd0);
    @(negedge clk); t_stop = 1'b0;

    // Saturation: preload the count just below full, then add 1 and 2.
    load_scn(3);
    start_run();
    @(negedge clk); drive(3, 0);
    force u0.r_errors = 32'hFFFF_FFFE;
    #1 release u0.r_errors;
    @(posedge clk);
    for (int t = 1; t < 4; t++) begin
      @(negedge clk); drive(3, t);
      @(posedge clk);
    end
    #1;
    chk("sat_err", 64'(b0.doErrors), 64'hFFFF_FFFF);
    chk("sat_done", 64'({b0.coDone, b0.coPass}), 64'b10);
    chk("sat_err_u1", 64'(b1.doErrors), 64'd3);

    // Load attempted mid-run, then reset mid-run; a rerun must match run 0.
    load_scn(0);
    @(negedge clk); t_start = 1'b1;
    @(posedge clk);
    @(negedge clk); t_start = 1'b0; t_load = 1'b1; t_addr = 10'd1; t_data = MARK;
    @(posedge clk);
    @(negedge clk); drive(0, 0);
    @(posedge clk);
    @(negedge clk); t_load = 1'b0; drive(0, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out0", {b0.coBusy, b0.coDone, b0.coPass, b0.coFirstValid, b0.doErrors,
                        21'(b0.doVecNum), 8'(b0.doFirstCh)}, 64'd0);
    chk("midrst_out1", {b1.coBusy, b1.coDone, b1.coPass, 8'(b1.doVecNum)}, 64'd0);
    #2 rst_n = 1'b1;
    run_scn(0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
